// File: rtl/harmonic_synth_seq_if.sv
// Request/response bundle of the harmonic synthesizer.
// The master issues sample requests; the slave returns saturated sums.
interface harmonic_synth_seq_if #(
    parameter int WIDTH    = 24,
    parameter int HARMONIC = 16
);
    localparam int NW  = $clog2(HARMONIC + 1);
    localparam int GS  = $clog2(HARMONIC);
    localparam int GSW = (GS < 1) ? 1 : $clog2(GS + 1);

    logic                       i_start;
    logic                       o_ready;
    logic [WIDTH-1:0]           i_angle;
    logic [HARMONIC*WIDTH-1:0]  i_harmo_amp;
    logic [NW-1:0]              i_active_harm;
    logic [GSW-1:0]             i_gain_shift;
    logic signed [WIDTH-1:0]    o_sample;
    logic                       o_sample_valid;
    logic                       o_sat;

    modport master (
        output i_start, i_angle, i_harmo_amp, i_active_harm, i_gain_shift,
        input  o_ready, o_sample, o_sample_valid, o_sat
    );

    modport slave (
        input  i_start, i_angle, i_harmo_amp, i_active_harm, i_gain_shift,
        output o_ready, o_sample, o_sample_valid, o_sat
    );
endinterface

// File: rtl/harmonic_synth_seq.sv
// Time-multiplexed additive synthesizer: one iterative CORDIC sine core and one MAC
// step through the active harmonics, then the sum is gain-shifted and saturated.
module harmonic_synth_seq #(
    parameter int WIDTH    = 24,
    parameter int HARMONIC = 16,
    parameter int ITER     = 16
) (
    input  logic                clk,
    input  logic                rst,
    harmonic_synth_seq_if.slave bus
);
    localparam int GS   = $clog2(HARMONIC);
    localparam int NW   = $clog2(HARMONIC + 1);
    localparam int GSW  = (GS < 1) ? 1 : $clog2(GS + 1);
    localparam int IW   = (ITER < 2) ? 1 : $clog2(ITER);
    localparam int ZW   = WIDTH + 2;
    localparam int PW   = WIDTH + ZW;
    localparam int ACCW = WIDTH + GS + 1;
    localparam int AW   = HARMONIC * WIDTH;

    localparam logic signed [ZW-1:0]   X0   = ZW'($rtoi(0.6072529 * (2.0 ** (WIDTH - 2)) + 0.5));
    localparam logic signed [ACCW-1:0] SMAX = ACCW'((64'sd1 <<< (WIDTH - 1)) - 64'sd1);
    localparam logic signed [ACCW-1:0] SMIN = ~SMAX;

    // atan(2^-i) scaled so that 2^WIDTH is a full turn; the series converges for i >= 1.
    function automatic longint atan_lsb(input int i);
        real t;
        real t2;
        real term;
        real ang;
        t = 1.0;
        for (int j = 0; j < i; j++) t = t / 2.0;
        if (i == 0) begin
            ang = 0.78539816339744831;
        end else begin
            ang  = 0.0;
            term = t;
            t2   = t * t;
            for (int m = 0; m < 24; m++) begin
                ang  = ang + (((m % 2) == 0) ? term : -term) / real'(2 * m + 1);
                term = term * t2;
            end
        end
        return longint'($rtoi(ang * (2.0 ** WIDTH) / 6.2831853071795865 + 0.5));
    endfunction

    // Returns {saturated, clamped value}.
    function automatic logic [WIDTH:0] saturate(input logic signed [ACCW-1:0] v);
        if (v > SMAX) return {1'b1, SMAX[WIDTH-1:0]};
        if (v < SMIN) return {1'b1, SMIN[WIDTH-1:0]};
        return {1'b0, v[WIDTH-1:0]};
    endfunction

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ROT, S_MAC, S_OUT} state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [WIDTH-1:0]        r_angle;
    logic [WIDTH-1:0]        r_phase;
    logic [AW-1:0]           r_amps;
    logic [NW-1:0]           r_n;
    logic [NW-1:0]           r_k;
    logic [GSW-1:0]          r_gs;
    logic [IW-1:0]           r_i;
    logic signed [ZW-1:0]    r_x;
    logic signed [ZW-1:0]    r_y;
    logic signed [ZW-1:0]    r_z;
    logic                    r_neg;
    logic signed [ACCW-1:0]  r_acc;
    logic signed [WIDTH-1:0] r_sample;
    logic                    r_valid;
    logic                    r_sat;

    logic [NW-1:0]           w_n;
    logic [GSW-1:0]          w_gs;
    logic                    w_fold;
    logic [WIDTH-1:0]        w_zin;
    logic signed [ZW-1:0]    w_atan [ITER];
    logic signed [ZW-1:0]    w_xs;
    logic signed [ZW-1:0]    w_ys;
    logic signed [ZW-1:0]    w_s;
    logic signed [WIDTH-1:0] w_amp;
    logic signed [PW-1:0]    w_prod;
    logic signed [ACCW-1:0]  w_term;
    logic signed [ACCW-1:0]  w_shift;
    logic [WIDTH:0]          w_res;

    for (genvar g = 0; g < ITER; g++) begin : g_atan
        localparam longint ATAN_G = atan_lsb(g);
        assign w_atan[g] = ZW'(ATAN_G);
    end

    assign w_n  = (bus.i_active_harm > NW'(HARMONIC)) ? NW'(HARMONIC) : bus.i_active_harm;
    assign w_gs = (bus.i_gain_shift > GSW'(GS)) ? GSW'(GS) : bus.i_gain_shift;

    // Quadrants 2 and 3 are mirrored into [-pi/2, pi/2) by flipping the MSB; sin changes sign.
    assign w_fold = r_phase[WIDTH-1] ^ r_phase[WIDTH-2];
    assign w_zin  = {r_phase[WIDTH-1] ^ w_fold, r_phase[WIDTH-2:0]};

    assign w_xs   = r_x >>> r_i;
    assign w_ys   = r_y >>> r_i;
    assign w_s    = r_neg ? -r_y : r_y;
    assign w_amp  = r_amps[WIDTH-1:0];
    assign w_prod = PW'(w_amp) * PW'(w_s);
    assign w_term = ACCW'(w_prod >>> (WIDTH - 2));

    assign w_shift = r_acc >>> r_gs;
    assign w_res   = saturate(w_shift);

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.i_start) w_next = (w_n == '0) ? S_OUT : S_LOAD;
            S_LOAD:  w_next = S_ROT;
            S_ROT:   if (r_i == IW'(ITER - 1)) w_next = S_MAC;
            S_MAC:   w_next = ((r_k + NW'(1)) == r_n) ? S_OUT : S_LOAD;
            S_OUT:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        case (r_state)
            S_IDLE: begin
                if (bus.i_start) begin
                    r_angle <= bus.i_angle;
                    r_phase <= bus.i_angle;
                    r_amps  <= bus.i_harmo_amp;
                    r_n     <= w_n;
                    r_gs    <= w_gs;
                    r_k     <= '0;
                    r_acc   <= '0;
                end
            end
            S_LOAD: begin
                r_x   <= X0;
                r_y   <= '0;
                r_z   <= {{2{w_zin[WIDTH-1]}}, w_zin};
                r_neg <= w_fold;
                r_i   <= '0;
            end
            S_ROT: begin
                if (!r_z[ZW-1]) begin
                    r_x <= r_x - w_ys;
                    r_y <= r_y + w_xs;
                    r_z <= r_z - w_atan[r_i];
                end else begin
                    r_x <= r_x + w_ys;
                    r_y <= r_y - w_xs;
                    r_z <= r_z + w_atan[r_i];
                end
                r_i <= r_i + IW'(1);
            end
            S_MAC: begin
                r_acc   <= r_acc + w_term;
                r_phase <= r_phase + r_angle;
                r_k     <= r_k + NW'(1);
                r_amps  <= r_amps >> WIDTH;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sample <= '0;
            r_sat    <= 1'b0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= (r_state == S_OUT);
            if (r_state == S_OUT) begin
                r_sample <= w_res[WIDTH-1:0];
                r_sat    <= w_res[WIDTH];
            end
        end
    end

    assign bus.o_ready        = (r_state == S_IDLE);
    assign bus.o_sample       = r_sample;
    assign bus.o_sample_valid = r_valid;
    assign bus.o_sat          = r_sat;
endmodule
